// File: rtl/vend_pkg.sv
// Shared constants and types for the multi-product vending controller.
// Credit and coin values are counted in nickel units (1 = 5c).
package vend_pkg;

  localparam int unsigned VAL_NICKEL  = 1;
  localparam int unsigned VAL_DIME    = 2;
  localparam int unsigned VAL_QUARTER = 5;

  typedef enum logic [0:0] {
    ST_ACCEPT,
    ST_CHANGE
  } vend_state_e;

endpackage

// File: rtl/vend_change_unit.sv
// Greedy change selector: picks the largest returnable coin that fits the remaining credit
// and reports how much that coin takes off the credit.
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] remaining,
  output logic                give_nickel,
  output logic                give_dime,
  output logic                give_quarter,
  output logic [CREDIT_W-1:0] dec
);

  always_comb begin
    give_nickel  = 1'b0;
    give_dime    = 1'b0;
    give_quarter = 1'b0;
    dec          = '0;
    if (remaining >= CREDIT_W'(VAL_QUARTER)) begin
      give_quarter = 1'b1;
      dec          = CREDIT_W'(VAL_QUARTER);
    end else if (remaining >= CREDIT_W'(VAL_DIME)) begin
      give_dime = 1'b1;
      dec       = CREDIT_W'(VAL_DIME);
    end else begin
      // Also selected for zero credit; the caller only consumes it while credit is nonzero.
      give_nickel = 1'b1;
      dec         = CREDIT_W'(VAL_NICKEL);
    end
  end

endmodule

// File: rtl/vend_multi_product.sv
// Multi-product vending controller with a binary credit accumulator and a serial,
// greedy coin-return stream for change and cancel refunds. All outputs are registered.
module vend_multi_product
  import vend_pkg::*;
#(
  parameter int unsigned                         CREDIT_W     = 8,
  parameter int unsigned                         NUM_PRODUCTS = 4,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0]    PRICES       = {8'd15, 8'd10, 8'd7, 8'd5},
  parameter int unsigned                         MAX_CREDIT   = 40,
  parameter int unsigned                         SEL_W        =
      (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                coin_nickel,
  input  logic                coin_dime,
  input  logic                coin_quarter,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_id,
  output logic                ret_nickel,
  output logic                ret_dime,
  output logic                ret_quarter,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                sel_nack
);

  vend_state_e state_q;

  logic                any_coin;
  logic                multi_coin;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [31:0]         sel_idx;
  logic                sel_ok;
  logic [CREDIT_W-1:0] price;
  logic                can_buy;

  logic                chg_nickel;
  logic                chg_dime;
  logic                chg_quarter;
  logic [CREDIT_W-1:0] chg_dec;

  vend_change_unit #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .remaining    (credit),
    .give_nickel  (chg_nickel),
    .give_dime    (chg_dime),
    .give_quarter (chg_quarter),
    .dec          (chg_dec)
  );

  // Coin decode: nickel beats dime beats quarter; any extra coin in the cycle is rejected.
  always_comb begin
    any_coin   = coin_nickel | coin_dime | coin_quarter;
    multi_coin = (coin_nickel & coin_dime) | (coin_nickel & coin_quarter) |
                 (coin_dime & coin_quarter);
    if (coin_nickel) begin
      coin_val = CREDIT_W'(VAL_NICKEL);
    end else if (coin_dime) begin
      coin_val = CREDIT_W'(VAL_DIME);
    end else begin
      coin_val = CREDIT_W'(VAL_QUARTER);
    end
    coin_sum  = {1'b0, credit} + {1'b0, coin_val};
    coin_fits = coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT);
  end

  always_comb begin
    sel_idx = 32'(sel_id);
    sel_ok  = sel_idx < NUM_PRODUCTS;
    price   = '0;
    for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_idx == i) begin
        price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
    can_buy = sel_ok && (credit >= price);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_ACCEPT;
      dispense    <= 1'b0;
      dispense_id <= '0;
      ret_nickel  <= 1'b0;
      ret_dime    <= 1'b0;
      ret_quarter <= 1'b0;
      credit      <= '0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
      sel_nack    <= 1'b0;
    end else begin
      dispense    <= 1'b0;
      dispense_id <= '0;
      ret_nickel  <= 1'b0;
      ret_dime    <= 1'b0;
      ret_quarter <= 1'b0;
      coin_reject <= 1'b0;
      sel_nack    <= 1'b0;

      unique case (state_q)
        ST_ACCEPT: begin
          if (cancel) begin
            coin_reject <= any_coin;
            if (credit != '0) begin
              state_q <= ST_CHANGE;
              busy    <= 1'b1;
            end
          end else if (sel_valid) begin
            coin_reject <= any_coin;
            if (can_buy) begin
              dispense    <= 1'b1;
              dispense_id <= sel_id;
              credit      <= credit - price;
              if (credit != price) begin
                state_q <= ST_CHANGE;
                busy    <= 1'b1;
              end
            end else begin
              sel_nack <= 1'b1;
            end
          end else if (any_coin) begin
            coin_reject <= multi_coin | ~coin_fits;
            if (coin_fits) begin
              credit <= coin_sum[CREDIT_W-1:0];
            end
          end
        end

        ST_CHANGE: begin
          // busy falls together with the coin that empties the credit.
          coin_reject <= any_coin;
          sel_nack    <= sel_valid;
          ret_nickel  <= chg_nickel;
          ret_dime    <= chg_dime;
          ret_quarter <= chg_quarter;
          credit      <= credit - chg_dec;
          if (credit == chg_dec) begin
            state_q <= ST_ACCEPT;
            busy    <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_ACCEPT;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_multi_product.sv
// Randomized self-checking bench for vend_multi_product against a queue-based
// behavioural model of credit, purchases and coin refunds.
module tb_vend_multi_product;

  localparam int CREDIT_W = 8;
  localparam int SEL_W    = 2;
  localparam int NUM_P    = 4;
  localparam int MAX_CR   = 40;

  logic             clk;
  logic             reset_n;
  logic             coin_nickel;
  logic             coin_dime;
  logic             coin_quarter;
  logic             sel_valid;
  logic [SEL_W-1:0] sel_id;
  logic             cancel;
  logic             dispense;
  logic [SEL_W-1:0] dispense_id;
  logic             ret_nickel;
  logic             ret_dime;
  logic             ret_quarter;
  logic [CREDIT_W-1:0] credit;
  logic             busy;
  logic             coin_reject;
  logic             sel_nack;

  vend_multi_product u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .coin_nickel  (coin_nickel),
    .coin_dime    (coin_dime),
    .coin_quarter (coin_quarter),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .dispense     (dispense),
    .dispense_id  (dispense_id),
    .ret_nickel   (ret_nickel),
    .ret_dime     (ret_dime),
    .ret_quarter  (ret_quarter),
    .credit       (credit),
    .busy         (busy),
    .coin_reject  (coin_reject),
    .sel_nack     (sel_nack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: credit as an integer, refunds as a queue of coin values.
  int price_tab [NUM_P] = '{5, 7, 10, 15};
  int m_credit;
  int m_refund[$];
  int e_disp, e_id, e_rn, e_rd, e_rq, e_rej, e_nack, e_busy;

  task automatic queue_refund(input int amount);
    int r;
    r = amount;
    while (r >= 5) begin m_refund.push_back(5); r -= 5; end
    while (r >= 2) begin m_refund.push_back(2); r -= 2; end
    while (r >= 1) begin m_refund.push_back(1); r -= 1; end
  endtask

  task automatic model_step(input bit n, input bit d, input bit q, input bit sv,
                            input int sid, input bit c);
    int coins;
    int v;
    coins  = int'(n) + int'(d) + int'(q);
    e_disp = 0; e_id = 0; e_rn = 0; e_rd = 0; e_rq = 0; e_rej = 0; e_nack = 0;
    if (m_refund.size() > 0) begin
      v = m_refund.pop_front();
      m_credit -= v;
      e_rq   = (v == 5);
      e_rd   = (v == 2);
      e_rn   = (v == 1);
      e_rej  = (coins > 0);
      e_nack = sv;
    end else if (c) begin
      e_rej = (coins > 0);
      queue_refund(m_credit);
    end else if (sv) begin
      e_rej = (coins > 0);
      if (sid < NUM_P && m_credit >= price_tab[sid]) begin
        e_disp = 1;
        e_id   = sid;
        m_credit -= price_tab[sid];
        queue_refund(m_credit);
      end else begin
        e_nack = 1;
      end
    end else if (coins > 0) begin
      v     = n ? 1 : (d ? 2 : 5);
      e_rej = (coins > 1);
      if (m_credit + v <= MAX_CR) m_credit += v;
      else e_rej = 1;
    end
    e_busy = (m_refund.size() > 0);
  endtask

  task automatic check_all();
    check_eq("dispense", 32'(dispense), 32'(e_disp));
    if (e_disp != 0) check_eq("dispense_id", 32'(dispense_id), 32'(e_id));
    check_eq("ret_nickel", 32'(ret_nickel), 32'(e_rn));
    check_eq("ret_dime", 32'(ret_dime), 32'(e_rd));
    check_eq("ret_quarter", 32'(ret_quarter), 32'(e_rq));
    check_eq("credit", 32'(credit), 32'(m_credit));
    check_eq("busy", 32'(busy), 32'(e_busy));
    check_eq("coin_reject", 32'(coin_reject), 32'(e_rej));
    check_eq("sel_nack", 32'(sel_nack), 32'(e_nack));
  endtask

  task automatic step(input bit n, input bit d, input bit q, input bit sv,
                      input int sid, input bit c);
    @(negedge clk);
    coin_nickel  = n;
    coin_dime    = d;
    coin_quarter = q;
    sel_valid    = sv;
    sel_id       = SEL_W'(sid);
    cancel       = c;
    model_step(n, d, q, sv, sid, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_credit"}, 32'(credit), 0);
    check_eq({tag, "_outs"}, 32'({dispense, dispense_id, ret_nickel, ret_dime, ret_quarter,
                                  busy, coin_reject, sel_nack}), 0);
  endtask

  int busy_cycles;

  initial begin
    reset_n = 1'b0;
    coin_nickel = 0; coin_dime = 0; coin_quarter = 0;
    sel_valid = 0; sel_id = '0; cancel = 0;
    m_credit = 0;
    #3;
    check_zero_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Exact-price purchase: no change.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check_eq("tp1_dispense", 32'(dispense), 1);
    idle(2);

    // 10 credit, buy price 7: dime then nickel, busy for two cycles.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    check_eq("tp2_credit", 32'(credit), 3);
    check_eq("tp2_busy", 32'(busy), 1);
    idle(3);

    // Insufficient credit, then cancel refunds one dime; sel 3 refused.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check_eq("tp3_nack", 32'(sel_nack), 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check_eq("tp3_ret_dime", 32'(ret_dime), 1);
    step(0, 0, 0, 1, 3, 0);
    check_eq("tp3_nack3", 32'(sel_nack), 1);

    // Fill to MAX_CREDIT, overflow quarter rejected, cancel gives 8 quarters.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0);
    check_eq("tp4_full", 32'(credit), 40);
    step(0, 0, 1, 0, 0, 0);
    check_eq("tp4_reject", 32'(coin_reject), 1);
    step(0, 0, 0, 0, 0, 1);
    busy_cycles = int'(busy);
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0, 0, 0);
      busy_cycles += int'(busy);
    end
    check_eq("tp4_busy_cycles", 32'(busy_cycles), 8);

    // Coin with selection in the same cycle; nickel+dime together.
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    check_eq("tp5_reject", 32'(coin_reject), 1);
    step(1, 1, 0, 0, 0, 0);
    check_eq("tp5_credit", 32'(credit), 1);
    step(0, 0, 0, 0, 0, 1);
    idle(2);

    // Asynchronous reset in the middle of a change stream.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    m_credit = 0;
    m_refund.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 0, 1, 0, 0, 0);
    check_eq("post_reset_credit", 32'(credit), 5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
